// File: rtl/matrix_scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : matrix_scan_sched
// Brief    : HUB75 row scan scheduler (SHIFT/LATCH/SHOW/BLANK) with
//            frame-boundary framebuffer swap.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_scan_sched #(
  parameter int COLS = 64,
  parameter int ROWS = 16,
  parameter int BW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [BW-1:0] brightness,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          front_buf,
  output logic [6:0]    col,
  output logic [3:0]    row,
  output logic          shift_en,
  output logic          LAT,
  output logic          OE,
  output logic          frame_done,
  output logic          busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SHOW  = 3'd3;
  localparam logic [2:0] S_BLANK = 3'd4;

  localparam logic [6:0]    COL_LAST = 7'(COLS - 1);
  localparam logic [3:0]    ROW_LAST = 4'(ROWS - 1);
  localparam logic [BW-1:0] ONE      = BW'(1);

  logic [2:0]    state_q, state_d;
  logic [6:0]    col_q, col_d;
  logic [3:0]    row_q, row_d;
  logic [BW-1:0] on_cnt_q, on_cnt_d;
  logic          front_buf_q, front_buf_d;
  logic          swap_ack_q, swap_ack_d;
  logic          frame_done_q, frame_done_d;
  logic          shift_en_q, shift_en_d;
  logic          lat_q, lat_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      on_cnt_q     <= '0;
      front_buf_q  <= 1'b0;
      swap_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
      shift_en_q   <= 1'b0;
      lat_q        <= 1'b0;
      oe_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      on_cnt_q     <= on_cnt_d;
      front_buf_q  <= front_buf_d;
      swap_ack_q   <= swap_ack_d;
      frame_done_q <= frame_done_d;
      shift_en_q   <= shift_en_d;
      lat_q        <= lat_d;
      oe_q         <= oe_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    on_cnt_d     = on_cnt_q;
    front_buf_d  = front_buf_q;
    swap_ack_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        row_d = '0;
        col_d = '0;
        if (enable) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (col_q == COL_LAST) begin
          col_d   = '0;
          state_d = S_LATCH;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      S_LATCH: begin
        on_cnt_d = brightness;
        state_d  = (brightness != '0) ? S_SHOW : S_BLANK;
      end
      S_SHOW: begin
        if (on_cnt_q == ONE) state_d = S_BLANK;
        else                 on_cnt_d = on_cnt_q - ONE;
      end
      S_BLANK: begin
        // Frame boundary is the only point where a buffer swap may be granted.
        if (row_q == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
          if (swap_req) begin
            front_buf_d = ~front_buf_q;
            swap_ack_d  = 1'b1;
          end
        end else begin
          row_d = row_q + 4'd1;
        end
        if (enable) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
          row_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  // Panel controls are registered from the next state so they align with state_q.
  always_comb begin
    shift_en_d = (state_d == S_SHIFT);
    lat_d      = (state_d == S_LATCH);
    oe_d       = (state_d != S_SHOW);
    busy_d     = (state_d != S_IDLE);
  end

  assign swap_ack   = swap_ack_q;
  assign front_buf  = front_buf_q;
  assign col        = col_q;
  assign row        = row_q;
  assign shift_en   = shift_en_q;
  assign LAT        = lat_q;
  assign OE         = oe_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_sched.sv
`default_nettype none
// Directed bench for matrix_scan_sched: row timing, brightness, swap, enable drop, async reset.
module tb_matrix_scan_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] brightness = 8'd4;
  logic       swap_req = 1'b0;
  logic       swap_ack, front_buf, shift_en, LAT, OE, frame_done, busy;
  logic [6:0] col;
  logic [3:0] row;

  int checks = 0;
  int failures = 0;
  logic exp_fb = 1'b0;

  matrix_scan_sched #(.COLS(64), .ROWS(16), .BW(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .brightness(brightness),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_buf(front_buf),
    .col(col), .row(row), .shift_en(shift_en), .LAT(LAT), .OE(OE),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {OE, LAT, shift_en, col, row, front_buf, swap_ack, frame_done, busy},
        {1'b1, 1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  // Walks one full row starting from the edge that enters SHIFT; returns in BLANK.
  task automatic run_row(input int r, input int on, input int nb, input int drop_col);
    for (int i = 0; i < 64; i++) begin
      tick();
      if (i == drop_col) enable = 1'b0;
      chk("shift", {shift_en, OE, LAT, busy, front_buf, row, col},
          {1'b1, 1'b1, 1'b0, 1'b1, exp_fb, 4'(r), 7'(i)});
      if (i > 0) chk("no_pulse", {frame_done, swap_ack}, 2'b00);
    end
    tick();
    chk("latch", {LAT, OE, shift_en, col, row}, {1'b1, 1'b1, 1'b0, 7'd0, 4'(r)});
    for (int j = 0; j < on; j++) begin
      tick();
      if (j == 0 && nb >= 0) brightness = 8'(nb);
      chk("show", {OE, LAT, shift_en, row}, {1'b0, 1'b0, 1'b0, 4'(r)});
    end
    tick();
    chk("blank", {OE, LAT, shift_en, row}, {1'b1, 1'b0, 1'b0, 4'(r)});
  endtask

  initial begin
    int  cnt;
    logic oe_low;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset_vals");
    rst = 1'b0;
    enable = 1'b1;

    run_row(0, 4, -1, -1);
    run_row(1, 4, -1, -1);
    run_row(2, 4, 9, -1);
    run_row(3, 9, -1, -1);
    brightness = 8'd0;
    run_row(4, 0, -1, -1);
    run_row(5, 0, -1, 20);
    tick();
    chk("idle_after_drop", {busy, OE, LAT, shift_en, row, col, frame_done, swap_ack},
        {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, 1'b0});
    tick();
    chk("idle_hold", {busy, OE, row}, {1'b0, 1'b1, 4'd0});
    enable = 1'b1;

    for (int r = 0; r < 16; r++) begin
      if (r == 8) swap_req = 1'b1;
      run_row(r, 0, -1, -1);
    end
    tick();
    chk("swap_frame_end", {frame_done, swap_ack, front_buf, row, shift_en},
        {1'b1, 1'b1, 1'b1, 4'd0, 1'b1});
    exp_fb = 1'b1;
    swap_req = 1'b0;

    cnt = 0;
    oe_low = 1'b0;
    do begin
      tick();
      cnt++;
      if (OE == 1'b0) oe_low = 1'b1;
    end while (frame_done !== 1'b1 && cnt < 2000);
    chk("frame_period_b0", cnt, 32'd1056);
    chk("oe_never_low_b0", {31'd0, oe_low}, 32'd0);
    chk("no_second_swap", {swap_ack, front_buf}, {1'b0, 1'b1});

    brightness = 8'd4;
    swap_req = 1'b1;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!(row == 4'd15 && OE == 1'b0) && cnt < 3000);
    chk("reach_row15_show", {row, OE}, {4'd15, 1'b0});
    tick();
    #2 rst = 1'b1;
    #1;
    chk_reset("async_reset_vals");
    @(posedge clk);
    #1;
    chk_reset("reset_held");
    rst = 1'b0;
    swap_req = 1'b0;
    chk("idle_after_reset", {busy, shift_en}, 2'b00);
    tick();
    chk("restart_shift", {shift_en, busy, row, col, front_buf},
        {1'b1, 1'b1, 4'd0, 7'd0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/matrix_scan_sched.md
Name: matrix_scan_sched

Overview:
Scan scheduler for the 64x32 HUB75 LED panel. Sequences each panel row through shift, latch, display and blank phases, and produces the panel control signals (column/row addresses, shift enable, LAT, OE). Brightness is set by the OE-low on-time. Owns the double-buffered framebuffer select: the game logic requests a buffer swap, and the swap is granted only at a frame boundary. It sits between the game-control FSM / framebuffer and the pixel output registers that feed the panel.

Parameters:
COLS, 64, pixels shifted per row (per half-panel); must be >= 2.
ROWS, 16, row addresses per frame; each address lights two physical rows.
BW, 8, width of the brightness input.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
enable  input  1  level; 1 = run scanning (driven by the gaming state)
brightness  input  BW  OE-low cycles per row; sampled at LATCH
swap_req  input  1  level; game logic requests a front/back buffer swap
swap_ack  output  1  1-cycle pulse: swap granted, front_buf toggled this cycle
front_buf  output  1  framebuffer bank currently displayed
col  output  7  column address being shifted (framebuffer read address)
row  output  4  row address being loaded/shown (drives D,C,B,A)
shift_en  output  1  1 = pixel data on the RGB lines is valid to shift this cycle
LAT  output  1  panel latch strobe
OE  output  1  panel output enable, active-high = blanked
frame_done  output  1  1-cycle pulse at the end of the last row of a frame
busy  output  1  1 whenever state != IDLE

Behaviour:
- Interface: reset is rst, asynchronous, active-high; clock is clk. All outputs are registered.
- Reset values: OE=1, LAT=0, shift_en=0, col=0, row=0, front_buf=0, swap_ack=0, frame_done=0, busy=0. State is IDLE.
- FSM states: IDLE, SHIFT, LATCH, SHOW, BLANK.
- IDLE:
  - OE=1, LAT=0, row=0.
  - If enable=1, go to SHIFT with col=0.
- SHIFT:
  - Lasts exactly COLS cycles, with shift_en=1 throughout.
  - col counts 0..COLS-1, one value per cycle.
  - OE=1 throughout.
  - After col=COLS-1, go to LATCH. col returns to 0.
- LATCH:
  - Exactly 1 cycle, LAT=1, OE=1.
  - Samples brightness into on_cnt.
  - Next state is SHOW if the sampled value is nonzero, else BLANK.
- SHOW:
  - OE=0 for exactly on_cnt cycles, LAT=0.
  - brightness changes during SHOW have no effect until the next LATCH.
- BLANK:
  - Exactly 1 cycle, OE=1 (anti-ghosting).
  - Row advance rules:
    - If row < ROWS-1: row increments. Next state is SHIFT if enable, else IDLE (row cleared to 0).
    - If row = ROWS-1: frame_done pulses, row wraps to 0, and the next state is SHIFT if enable, else IDLE.
- Row timing:
  - row holds the same value from the first SHIFT cycle through BLANK.
  - Row period = COLS + 2 + brightness cycles.
  - Frame period = ROWS x row period (constant brightness).
- Swap:
  - swap_req is sampled only in the BLANK cycle of row ROWS-1.
  - If swap_req=1 there: front_buf toggles, and swap_ack pulses in the same cycle as frame_done.
  - swap_req high at any other time is held pending (level) and causes no action.
  - The requester must drop swap_req after swap_ack. If it is still high at the next frame end, a second swap occurs.
- enable deasserted mid-row: the current row completes (SHIFT..BLANK) unchanged, then the FSM goes to IDLE. No frame_done or swap occurs unless that row was ROWS-1.
- enable asserted in IDLE: scanning always restarts at row 0, col 0.
- Counter widths:
  - col counts in 7 bits.
  - on_cnt is BW bits and counts down to 1, then exits SHOW.
  - row wraps modulo ROWS.
- Async reset at any point: all outputs take their reset values immediately. front_buf returns to 0, and no swap_ack is generated.

Test Plan:
- brightness=4, enable=1 from reset -> shift_en high 64 cycles with col 0..63, LAT=1 on cycle 65, OE=0 for cycles 66-69, OE=1 on cycle 70, row 0->1. Row period is 70 cycles.
- brightness=0 -> OE never 0 over a full frame, row period 66, frame_done every 1056 cycles.
- swap_req=1 held from mid-frame -> swap_ack and frame_done pulse in the same cycle at the end of row 15, front_buf 0->1. Then with swap_req=0 at the next frame end -> no swap_ack, front_buf stays 1.
- enable dropped during SHIFT of row 5 (col=20) -> row 5 completes LATCH/SHOW/BLANK, then IDLE with row=0, OE=1, busy=0, no frame_done. Re-enable -> first SHIFT is row 0.
- brightness changed 4->9 during SHOW of row 2 -> row 2 OE-low stays 4 cycles, row 3 OE-low is 9 cycles.
- rst asserted asynchronously during SHOW of row 15 with swap_req=1 -> OE=1, LAT=0, row=0, col=0, front_buf=0, no swap_ack, and the FSM restarts in IDLE after rst is released.
